sa_tile_sequencer: RTL and testbench
====================================

Name: sa_tile_sequencer

Overview:
Sequences one output tile on the 4x4 weight-stationary-free systolic array: fetches K weight and K feature vectors from two single-port read buffers and streams them, aligned, into the array's w_in/f_in. It asserts the array's start_clr with the first vector and waits out the internal skew/propagation drain. It then holds a result-valid handshake until the consumer has captured pe_results. It sits between the conv-module top-level FSM (start/config) and the systolic array plus its operand buffers.

Parameters:
DATA_WIDTH, 8, operand element width
ARRAY_SIZE, 4, array rows = cols = elements per vector
ADDR_WIDTH, 10, operand buffer address width
K_WIDTH, 10, width of reduction-length field
DRAIN_CYCLES, 9, cycles after last vector presented before results valid; legal range is at least 2*ARRAY_SIZE

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  tile start request, sampled only in IDLE
abort  in  1  synchronous abort, any state
k_len  in  K_WIDTH  reduction length K (vectors per operand)
w_base  in  ADDR_WIDTH  weight buffer start address
f_base  in  ADDR_WIDTH  feature buffer start address
busy  out  1  high in any state other than IDLE
w_rd_en  out  1  weight buffer read enable
w_rd_addr  out  ADDR_WIDTH  weight buffer read address
w_rd_data  in  ARRAY_SIZE*DATA_WIDTH  weight read data, valid 1 cycle after w_rd_en
f_rd_en  out  1  feature buffer read enable
f_rd_addr  out  ADDR_WIDTH  feature buffer read address
f_rd_data  in  ARRAY_SIZE*DATA_WIDTH  feature read data, valid 1 cycle after f_rd_en
sa_start_clr  out  1  to array start_clr
sa_w_in  out  ARRAY_SIZE*DATA_WIDTH  to array w_in
sa_f_in  out  ARRAY_SIZE*DATA_WIDTH  to array f_in
res_valid  out  1  array pe_results hold the completed tile
res_ready  in  1  consumer has captured / is capturing pe_results
tile_done  out  1  one-cycle pulse on the res_valid&&res_ready handshake

Behaviour:
- Reset: state=IDLE; busy, w_rd_en, f_rd_en, sa_start_clr, res_valid and tile_done are 0; addresses 0; sa_w_in/sa_f_in 0; all counters 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: when start=1 and k_len!=0, latch k_len, w_base and f_base, clear cnt, and go to LOAD. When start=1 and k_len==0, ignore the request and stay IDLE. Config inputs are don't-care outside the start cycle.
- LOAD: lasts exactly K cycles. Each cycle drives w_rd_en=f_rd_en=1, w_rd_addr=w_base+cnt and f_rd_addr=f_base+cnt (modulo 2^ADDR_WIDTH; addresses wrap). cnt increments each cycle. After the cnt==K-1 cycle, go to DRAIN with dcnt=0.
- Feed path: the registered flag feed_vld equals rd_en delayed by 1. sa_w_in=feed_vld?w_rd_data:0 and sa_f_in=feed_vld?f_rd_data:0 (combinational mux). The array therefore sees zero vectors whenever no read data is valid, and trailing zeros add nothing to the sums.
- sa_start_clr: high for exactly one cycle, the cycle the first vector (cnt=0 data) is presented, i.e. the first LOAD cycle +1. It is never high otherwise.
- DRAIN: the first DRAIN cycle presents the last vector. dcnt counts 0..DRAIN_CYCLES-1, then the block goes to DONE. Start at this point is ignored.
- DONE: res_valid=1 and stays high until res_ready=1. On the handshake cycle, tile_done=1, and the block goes to IDLE next cycle with res_valid=0. No new tile can start until then, which prevents start_clr from corrupting unconsumed results.
- Latency: start accepted at cycle S. Reads occur at S+1..S+K. The first vector is presented at S+2 with sa_start_clr. The last vector is presented at S+K+1. res_valid rises at S+K+1+DRAIN_CYCLES. busy is high S+1 onward, through the handshake cycle.
- start is accepted in the same cycle the block returns to IDLE; no back-to-back overlap within one cycle.
- abort=1 in any state: the next state is IDLE. rd_en, feed_vld, sa_start_clr and res_valid are cleared next cycle, and tile_done is not pulsed. abort has priority over start and res_ready. Array contents after abort are undefined; the next tile's start_clr reinitialises them.
- Max K = 2^K_WIDTH-1. cnt must be K_WIDTH wide with no overflow at max K.
- Async reset mid-tile: immediate return to reset values. No partial-tile state survives.

Test Plan:
- K=3, w_base=0x10, f_base=0x20, start at S, res_ready tied 1 -> reads at addr 0x10/0x20, 0x11/0x21, 0x12/0x22 on S+1..S+3; sa_start_clr only at S+2; sa_w_in non-zero only S+2..S+4; res_valid at S+13 for 1 cycle with tile_done; array PE sums match a golden 4x4x3 matmul.
- K=5 with res_ready held 0 for 7 cycles after res_valid -> res_valid stays high 8 cycles; start pulsed during DONE is ignored (no rd_en); tile_done only on the handshake cycle.
- start with k_len=0 -> busy stays 0, no rd_en, no sa_start_clr; then k_len=1 -> single read, res_valid at S+1+1+9.
- w_base=0x3FE, K=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- abort asserted on the 2nd LOAD cycle of K=6 -> rd_en drops next cycle, busy=0, no res_valid/tile_done; a following K=2 tile produces correct results (start_clr clears stale sums).
- rstn asserted during DRAIN -> all outputs at reset values immediately; after release, a new K=4 tile completes correctly.

Source files
------------

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for the 4x4 systolic array: streams K weight/feature vectors
// from the operand buffers into the array, waits out the drain, then hands off results.
module sa_tile_sequencer #(
   parameter int DATA_WIDTH   = 8,
   parameter int ARRAY_SIZE   = 4,
   parameter int ADDR_WIDTH   = 10,
   parameter int K_WIDTH      = 10,
   parameter int DRAIN_CYCLES = 9
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             start,
   input  logic                             abort,
   input  logic [K_WIDTH-1:0]               k_len,
   input  logic [ADDR_WIDTH-1:0]            w_base,
   input  logic [ADDR_WIDTH-1:0]            f_base,
   output logic                             busy,
   output logic                             w_rd_en,
   output logic [ADDR_WIDTH-1:0]            w_rd_addr,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_rd_data,
   output logic                             f_rd_en,
   output logic [ADDR_WIDTH-1:0]            f_rd_addr,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] f_rd_data,
   output logic                             sa_start_clr,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sa_w_in,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sa_f_in,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic                             tile_done
);

   localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [K_WIDTH-1:0]    cnt_q, cnt_d;
   logic [K_WIDTH-1:0]    k_q, k_d;
   logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
   logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
   logic [ADDR_WIDTH-1:0] f_base_q, f_base_d;
   logic                  feed_vld_q, feed_vld_d;
   logic                  start_clr_q, start_clr_d;
   logic                  rd_en;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         k_q         <= '0;
         dcnt_q      <= '0;
         w_base_q    <= '0;
         f_base_q    <= '0;
         feed_vld_q  <= 1'b0;
         start_clr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         dcnt_q      <= dcnt_d;
         w_base_q    <= w_base_d;
         f_base_q    <= f_base_d;
         feed_vld_q  <= feed_vld_d;
         start_clr_q <= start_clr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      dcnt_d      = dcnt_q;
      w_base_d    = w_base_q;
      f_base_d    = f_base_q;
      rd_en       = (state_q == LOAD);
      // Read data lands one cycle after the read, so the first vector and its clear go together.
      feed_vld_d  = rd_en && !abort;
      start_clr_d = rd_en && (cnt_q == '0) && !abort;

      case (state_q)
         IDLE: begin
            if (start && (k_len != '0)) begin
               state_d  = LOAD;
               k_d      = k_len;
               w_base_d = w_base;
               f_base_d = f_base;
               cnt_d    = '0;
            end
         end
         LOAD: begin
            cnt_d = cnt_q + K_WIDTH'(1);
            if (cnt_q == k_q - K_WIDTH'(1)) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q + DCNT_W'(1);
            if (dcnt_q == DCNT_W'(DRAIN_CYCLES - 1)) state_d = DONE;
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort) state_d = IDLE;
   end

   // Addresses wrap naturally at the buffer size.
   assign w_rd_addr    = w_base_q + ADDR_WIDTH'(cnt_q);
   assign f_rd_addr    = f_base_q + ADDR_WIDTH'(cnt_q);
   assign w_rd_en      = rd_en;
   assign f_rd_en      = rd_en;
   assign busy         = (state_q != IDLE);
   assign sa_start_clr = start_clr_q;
   assign sa_w_in      = feed_vld_q ? w_rd_data : '0;
   assign sa_f_in      = feed_vld_q ? f_rd_data : '0;
   assign res_valid    = (state_q == DONE);
   assign tile_done    = (state_q == DONE) && res_ready && !abort;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Directed bench for sa_tile_sequencer: buffer models, a small array accumulator,
// and per-cycle timeline checks against hand-derived latencies.
module tb_sa_tile_sequencer;

   localparam int DRAIN = 9;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start, abort, res_ready;
   logic [9:0]  k_len, w_base, f_base;
   logic        busy, w_rd_en, f_rd_en, sa_start_clr, res_valid, tile_done;
   logic [9:0]  w_rd_addr, f_rd_addr;
   logic [31:0] w_rd_data, f_rd_data, sa_w_in, sa_f_in;
   logic [31:0] acc [4][4];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sa_tile_sequencer #(
      .DATA_WIDTH(8), .ARRAY_SIZE(4), .ADDR_WIDTH(10), .K_WIDTH(10), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .k_len(k_len),
      .w_base(w_base), .f_base(f_base), .busy(busy),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .f_rd_en(f_rd_en), .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data),
      .sa_start_clr(sa_start_clr), .sa_w_in(sa_w_in), .sa_f_in(sa_f_in),
      .res_valid(res_valid), .res_ready(res_ready), .tile_done(tile_done)
   );

   function automatic logic [31:0] wval(input logic [9:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd3, b + 8'd2, b + 8'd1, b ^ 8'h5A};
   endfunction

   function automatic logic [31:0] fval(input logic [9:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b ^ 8'h33, b + 8'h40, b + 8'd7, b | 8'h01};
   endfunction

   // Single-port buffers with one-cycle read latency.
   always @(posedge clk) begin
      if (w_rd_en) w_rd_data <= wval(w_rd_addr);
      if (f_rd_en) f_rd_data <= fval(f_rd_addr);
   end

   // Output-stationary array stand-in: clear-and-load on start_clr, else accumulate.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            acc[i][j] <= (sa_start_clr ? 32'd0 : acc[i][j]) +
                         32'(sa_w_in[8*i +: 8]) * 32'(sa_f_in[8*j +: 8]);
   end

   task automatic run_tile(input int k, input logic [9:0] wb, input logic [9:0] fb,
                           input int rdly, input bit start_in_done);
      int          lat;
      logic [5:0]  exp_flags, obs_flags;
      logic [63:0] exp_data;
      logic [9:0]  ea, fa;
      logic [31:0] wv, fv;
      logic [31:0] gold [4][4];
      bit          sum_ok;
      lat = k + 1 + DRAIN + rdly;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) gold[i][j] = 0;
      for (int v = 0; v < k; v++) begin
         ea = wb + 10'(v);
         fa = fb + 10'(v);
         wv = wval(ea);
         fv = fval(fa);
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               gold[i][j] += 32'(wv[8*i +: 8]) * 32'(fv[8*j +: 8]);
      end
      @(posedge clk); #1;
      start = 1'b1; k_len = 10'(k); w_base = wb; f_base = fb; res_ready = 1'b0;
      for (int t = 1; t <= lat + 2; t++) begin
         @(posedge clk); #1;
         start     = start_in_done && (rdly >= 3) && (t == lat - rdly + 2);
         res_ready = (t >= lat);
         #1;
         exp_flags = {t <= lat, t <= k, t <= k, t == 2, t >= lat - rdly && t <= lat, t == lat};
         obs_flags = {busy, w_rd_en, f_rd_en, sa_start_clr, res_valid, tile_done};
         vectors++;
         if (obs_flags !== exp_flags) begin
            miscompares++;
            $display("[TB] FAIL flags k=%0d t=%0d {busy,wen,fen,clr,vld,done} got %b want %b",
                     k, t, obs_flags, exp_flags);
         end
         if (t >= 2 && t <= k + 1) exp_data = {wval(wb + 10'(t - 2)), fval(fb + 10'(t - 2))};
         else                      exp_data = 64'd0;
         vectors++;
         if ({sa_w_in, sa_f_in} !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL feed k=%0d t=%0d got %h want %h", k, t, {sa_w_in, sa_f_in}, exp_data);
         end
         if (t <= k) begin
            vectors++;
            if ({w_rd_addr, f_rd_addr} !== {wb + 10'(t - 1), fb + 10'(t - 1)}) begin
               miscompares++;
               $display("[TB] FAIL addr k=%0d t=%0d got %h/%h want %h/%h", k, t,
                        w_rd_addr, f_rd_addr, wb + 10'(t - 1), fb + 10'(t - 1));
            end
         end
         if (t == lat) begin
            sum_ok = 1'b1;
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  if (acc[i][j] !== gold[i][j]) sum_ok = 1'b0;
            vectors++;
            if (!sum_ok) begin
               miscompares++;
               $display("[TB] FAIL sums k=%0d acc00=%0d want %0d acc33=%0d want %0d",
                        k, acc[0][0], gold[0][0], acc[3][3], gold[3][3]);
            end
         end
      end
      start = 1'b0; res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      k_len = '0; w_base = '0; f_base = '0;
      repeat (2) @(posedge clk);
      #2;
      vectors++;
      if ({busy, w_rd_en, f_rd_en, sa_start_clr, res_valid, tile_done, w_rd_addr, f_rd_addr,
           sa_w_in, sa_f_in} !== 90'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state busy=%b wen=%b vld=%b waddr=%h sa_w=%h want all 0",
                  busy, w_rd_en, res_valid, w_rd_addr, sa_w_in);
      end
      @(posedge clk); #1; rstn = 1'b1;
   endtask

   task automatic test_basic();
      run_tile(3, 10'h010, 10'h020, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_tile(5, 10'h040, 10'h080, 7, 1'b1);
   endtask

   task automatic test_zero_k();
      @(posedge clk); #1;
      start = 1'b1; k_len = 10'd0; w_base = 10'h100; f_base = 10'h200;
      for (int t = 1; t <= 4; t++) begin
         @(posedge clk); #1; start = 1'b0; #1;
         vectors++;
         if ({busy, w_rd_en, f_rd_en, sa_start_clr} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL zero_k t=%0d {busy,wen,fen,clr} got %b want 0000",
                     t, {busy, w_rd_en, f_rd_en, sa_start_clr});
         end
      end
      run_tile(1, 10'h030, 10'h031, 0, 1'b0);
   endtask

   task automatic test_wrap();
      run_tile(4, 10'h3FE, 10'h3FD, 0, 1'b0);
   endtask

   task automatic test_abort();
      @(posedge clk); #1;
      start = 1'b1; k_len = 10'd6; w_base = 10'h050; f_base = 10'h060;
      for (int t = 1; t <= 10; t++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (t == 2);
         #1;
         if (t == 2) begin
            vectors++;
            if ({busy, w_rd_en} !== 2'b11) begin
               miscompares++;
               $display("[TB] FAIL abort_cycle {busy,wen} got %b want 11", {busy, w_rd_en});
            end
         end
         if (t >= 3) begin
            vectors++;
            if ({busy, w_rd_en, f_rd_en, sa_start_clr, res_valid, tile_done, sa_w_in} !== 38'd0) begin
               miscompares++;
               $display("[TB] FAIL after_abort t=%0d {busy,wen,fen,clr,vld,done}=%b sa_w=%h want 0",
                        t, {busy, w_rd_en, f_rd_en, sa_start_clr, res_valid, tile_done}, sa_w_in);
            end
         end
      end
      abort = 1'b0;
      run_tile(2, 10'h070, 10'h0F0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_drain();
      @(posedge clk); #1;
      start = 1'b1; k_len = 10'd4; w_base = 10'h011; f_base = 10'h022;
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      #1; rstn = 1'b0; #1;
      vectors++;
      if ({busy, w_rd_en, f_rd_en, sa_start_clr, res_valid, tile_done, w_rd_addr, f_rd_addr,
           sa_w_in, sa_f_in} !== 90'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_drain busy=%b wen=%b vld=%b waddr=%h sa_w=%h want all 0",
                  busy, w_rd_en, res_valid, w_rd_addr, sa_w_in);
      end
      repeat (2) @(posedge clk);
      #1; rstn = 1'b1;
      run_tile(4, 10'h011, 10'h022, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_k();
      test_wrap();
      test_abort();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
